fix_seq_num_alloc: RTL and testbench

- Upstream companion of the FIX sequence-number rewrite buffer in the router output port lookup path.
- Snoops the AXI-Stream beats entering the packet buffer's input FIFO and allocates one 6-digit BCD FIX MsgSeqNum per packet at packet start.
- Queues the allocated values in order; each packet's value is presented as fix_new_seq_num/fix_seq_num_vld.
- The rewrite stage pops one entry per packet via rd_fix_seq_num.

---
 rtl/fix_seq_num_alloc.sv | 139 +++++++++++++
 tb/tb_fix_seq_num_alloc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fix_seq_num_alloc.sv
// fix_seq_num_alloc: allocates one BCD FIX MsgSeqNum per snooped packet and queues them for the rewrite stage.
// Optional statistics ports are enabled by defining FIX_SEQ_NUM_STATS_EN.
module fix_seq_num_alloc #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SEQ_FIFO_DEPTH_BITS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            seq_num_load,
    input  logic [23:0]                     seq_num_load_val,
    input  logic                            rd_fix_seq_num,
    output logic [23:0]                     fix_new_seq_num,
    output logic                            fix_seq_num_vld,
    output logic                            alloc_ready,
    output logic                            overflow_err,
    output logic                            underflow_err
`ifdef FIX_SEQ_NUM_STATS_EN
    ,
    output logic [31:0]                     fix_alloc_count,
    output logic [23:0]                     last_alloc_seq
`endif
);
    localparam int AW = SEQ_FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int unused_data_width = C_S_AXIS_DATA_WIDTH;

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (r[i*4+:4] == 4'd9) r[i*4+:4] = 4'd0;
                else begin
                    r[i*4+:4] = r[i*4+:4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return (r == 24'd0) ? 24'h000001 : r;
    endfunction

    logic          in_pkt_q, in_pkt_d;
    logic [23:0]   next_seq_q, next_seq_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic [23:0]   mem [DEPTH];

    logic        accepted, first, is_fix, full, empty, pop, push;
    logic [15:0] pkt_type;
    logic [23:0] base;
    logic        unused_tuser;

    assign unused_tuser = ^{s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:64], s_axis_tuser[47:0]};
    assign accepted = s_axis_tvalid & s_axis_tready;
    assign first    = accepted & ~in_pkt_q;
    assign pkt_type = s_axis_tuser[63:48];
    assign is_fix   = pkt_type inside {[16'd5:16'd8]};
    assign full     = count_q == (AW+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign pop      = rd_fix_seq_num & ~empty;
    assign push     = first & (~full | pop);
    assign base     = seq_num_load ? seq_num_load_val : next_seq_q;

    assign fix_new_seq_num = mem[rd_ptr_q];
    assign fix_seq_num_vld = ~empty;
    assign alloc_ready     = ~full;
    assign overflow_err    = overflow_q;
    assign underflow_err   = underflow_q;

    // Next-state: packet tracking, sequence allocation, queue pointers and sticky errors
    always_comb begin
        in_pkt_d    = accepted ? ~s_axis_tlast : in_pkt_q;
        next_seq_d  = (push && is_fix) ? bcd_inc(base) : base;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d  = overflow_q | (first & full & ~pop);
        underflow_d = underflow_q | (rd_fix_seq_num & empty);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt_q    <= 1'b0;
            next_seq_q  <= 24'h000001;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            next_seq_q  <= next_seq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Queue storage: contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr_q] <= base;
    end

`ifdef FIX_SEQ_NUM_STATS_EN
    logic [31:0] fix_alloc_count_q, fix_alloc_count_d;
    logic [23:0] last_alloc_seq_q, last_alloc_seq_d;

    assign fix_alloc_count = fix_alloc_count_q;
    assign last_alloc_seq  = last_alloc_seq_q;

    // Statistics track only FIX allocations that actually entered the queue
    always_comb begin
        fix_alloc_count_d = fix_alloc_count_q + 32'(push & is_fix);
        last_alloc_seq_d  = (push && is_fix) ? base : last_alloc_seq_q;
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fix_alloc_count_q <= '0;
            last_alloc_seq_q  <= '0;
        end else begin
            fix_alloc_count_q <= fix_alloc_count_d;
            last_alloc_seq_q  <= last_alloc_seq_d;
        end
    end
`endif
endmodule

// File: tb/tb_fix_seq_num_alloc.sv
// tb_fix_seq_num_alloc: scoreboard bench for fix_seq_num_alloc against a decimal-arithmetic reference model.
module tb_fix_seq_num_alloc;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_axis_tvalid = 1'b0, s_axis_tready = 1'b0, s_axis_tlast = 1'b0;
    logic [127:0] s_axis_tuser = '0;
    logic         seq_num_load = 1'b0;
    logic [23:0]  seq_num_load_val = '0;
    logic         rd_fix_seq_num = 1'b0;
    logic [23:0]  fix_new_seq_num;
    logic         fix_seq_num_vld, alloc_ready, overflow_err, underflow_err;
`ifdef FIX_SEQ_NUM_STATS_EN
    logic [31:0]  fix_alloc_count;
    logic [23:0]  last_alloc_seq;
`endif

    fix_seq_num_alloc dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .seq_num_load(seq_num_load), .seq_num_load_val(seq_num_load_val),
        .rd_fix_seq_num(rd_fix_seq_num), .fix_new_seq_num(fix_new_seq_num),
        .fix_seq_num_vld(fix_seq_num_vld), .alloc_ready(alloc_ready),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
`ifdef FIX_SEQ_NUM_STATS_EN
        , .fix_alloc_count(fix_alloc_count), .last_alloc_seq(last_alloc_seq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit started = 0;

    // Reference model state (sequence number held as a plain decimal integer)
    int m_next, m_cnt, m_fcnt;
    bit m_inpkt, m_ovf, m_unf;
    int m_last;
    logic [23:0] exp_q[$];

    function automatic int bcd2int(input logic [23:0] b);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[i*4+:4]);
        return r;
    endfunction

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r;
        int x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances at each clock edge from the same inputs the DUT sees
    always @(posedge clk) begin
        if (reset) begin
            m_next = 1; m_cnt = 0; m_inpkt = 0; m_ovf = 0; m_unf = 0; m_fcnt = 0; m_last = 0;
            exp_q.delete();
        end else begin
            bit acc, first, fix, pop, push;
            int base, typ;
            acc   = s_axis_tvalid && s_axis_tready;
            first = acc && !m_inpkt;
            typ   = int'(s_axis_tuser[63:48]);
            fix   = typ >= 5 && typ <= 8;
            base  = seq_num_load ? bcd2int(seq_num_load_val) : m_next;
            pop   = rd_fix_seq_num && m_cnt > 0;
            if (rd_fix_seq_num && m_cnt == 0) m_unf = 1;
            push  = first && (m_cnt < 16 || pop);
            if (first && !push) m_ovf = 1;
            if (push) exp_q.push_back(int2bcd(base));
            if (push && fix) begin
                m_fcnt++;
                m_last = base;
            end
            m_next = (push && fix) ? (base == 999999 ? 1 : base + 1) : base;
            m_cnt  = m_cnt + int'(push) - int'(pop);
            if (acc) m_inpkt = !s_axis_tlast;
        end
    end

    // Monitor: status flags every cycle, queue head whenever the DUT delivers a value
    always @(negedge clk) begin
        if (started) begin
            chk("vld", 32'(fix_seq_num_vld), 32'(m_cnt != 0));
            chk("alloc_ready", 32'(alloc_ready), 32'(m_cnt != 16));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("underflow_err", 32'(underflow_err), 32'(m_unf));
`ifdef FIX_SEQ_NUM_STATS_EN
            chk("fix_alloc_count", fix_alloc_count, 32'(m_fcnt));
            chk("last_alloc_seq", 32'(last_alloc_seq), 32'(int2bcd(m_last)));
`endif
            if (rd_fix_seq_num && fix_seq_num_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seq_data: got %h expected no entry", fix_new_seq_num);
                end else chk("seq_data", 32'(fix_new_seq_num), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input bit tv, input bit tr, input bit tl, input int typ,
                       input bit ld, input logic [23:0] lv, input bit rd);
        s_axis_tvalid = tv;
        s_axis_tready = tr;
        s_axis_tlast  = tl;
        s_axis_tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_axis_tuser[63:48] = typ[15:0];
        seq_num_load = ld;
        seq_num_load_val = lv;
        rd_fix_seq_num = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 24'h0, 0);
    endtask

    task automatic pops(input int k);
        repeat (k) cyc(0, 0, 0, 0, 0, 24'h0, 1);
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
    endtask

    task automatic pkt(input int typ, input int n, input bit rnd = 0, input bit rd0 = 0,
                       input bit ld = 0, input logic [23:0] lv = 24'h0);
        bit tv, tr;
        for (int i = 0; i < n; i++) begin
            do begin
                tv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                tr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                cyc(tv, tr, i == n - 1, typ, ld && i == 0, lv,
                    rnd ? ($urandom_range(0, 3) == 0) : (rd0 && i == 0));
            end while (!(tv && tr));
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        started = 1;
        do_reset();
        // Three FIX packets, then drain in order
        repeat (3) pkt(5, 3);
        pops(4);
        // BCD wrap past 999999
        cyc(0, 0, 0, 0, 1, 24'h999998, 0);
        repeat (4) pkt(7, 2);
        pops(4);
        // Non-FIX packet reuses the value without incrementing
        cyc(0, 0, 0, 0, 1, 24'h000010, 0);
        pkt(5, 2);
        pkt(1, 3);
        pkt(6, 2);
        pkt(8, 1);
        pops(4);
        // Fill, same-cycle pop+push at full, then overflow
        repeat (16) pkt(5, 2);
        pkt(6, 2, 0, 1);
        pkt(5, 2);
        pops(17);
        // Single-beat packets keep in_pkt clear
        do_reset();
        pkt(5, 1);
        pkt(5, 1);
        pkt(2, 1);
        pops(3);
        // Load coincident with a FIX first beat
        pkt(5, 3, 0, 0, 1, 24'h000500);
        pkt(5, 2);
        pops(2);
        // Reset in the middle of a packet
        cyc(1, 1, 0, 5, 0, 24'h0, 0);
        cyc(1, 1, 0, 5, 0, 24'h0, 0);
        do_reset();
        pkt(5, 2);
        pops(1);
        // Randomized traffic with loads, stalls and pops
        do_reset();
        for (int k = 0; k < 300; k++) begin
            logic [23:0] lv;
            bit ld;
            ld = $urandom_range(0, 9) == 0;
            lv = ($urandom_range(0, 1) == 0) ? 24'h999998 : int2bcd(int'($urandom_range(0, 999999)));
            pkt(int'($urandom_range(0, 9)), int'($urandom_range(1, 4)), 1, 0, ld, lv);
            if (k % 60 == 59) pops(18);
        end
        pops(20);
        repeat (2) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
